miss_req_sched: RTL and testbench

Retransmission request scheduler. It sits downstream of the missing-message detector and upstream of the MoldUDP64 request packet builder. It takes gap reports from two requesters: same-session misses and session-spanning misses. Reports are arbitrated into a shared range FIFO, each range is split into MoldUDP64-legal requests of bounded message count, and requests are paced to the packet builder over a valid/ready handshake.

---
 rtl/miss_req_sched.sv | 145 ++++++++++++++
 tb/tb_miss_req_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miss_req_sched.sv
// miss_req_sched: arbitrates gap reports into a range FIFO and splits each range into
// paced, bounded-count MoldUDP64 retransmission requests.
module miss_req_sched #(
    parameter int SEQ_NUM_W   = 64,
    parameter int SID_W       = 80,
    parameter int ML_W        = 16,
    parameter int MAX_REQ_CNT = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYC     = 8,
    parameter int GAP_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 seq_v_i,
    input  logic [SID_W-1:0]     seq_sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_start_i,
    input  logic [SEQ_NUM_W-1:0] seq_cnt_i,
    input  logic                 sid_v_i,
    input  logic [SID_W-1:0]     sid_sid_i,
    input  logic [SEQ_NUM_W-1:0] sid_start_i,
    input  logic [SEQ_NUM_W-1:0] sid_cnt_i,
    output logic                 req_v_o,
    input  logic                 req_ready_i,
    output logic [SID_W-1:0]     req_sid_o,
    output logic [SEQ_NUM_W-1:0] req_seq_num_o,
    output logic [ML_W-1:0]      req_cnt_o,
    output logic                 busy_o,
    output logic                 ovf_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t               state_q, state_d;
    logic [SID_W-1:0]     sid_mem [FIFO_DEPTH];
    logic [SEQ_NUM_W-1:0] start_mem [FIFO_DEPTH];
    logic [SEQ_NUM_W-1:0] cnt_mem [FIFO_DEPTH];
    logic [PW-1:0]        rp_q, wp_q, seq_wa;
    logic [PW:0]          count_q, free;
    logic [SID_W-1:0]     cur_sid_q, cur_sid_d;
    logic [SEQ_NUM_W-1:0] cur_seq_q, cur_seq_d, rem_q, rem_d, chunk, rem_left;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 ovf_q, sid_ok, seq_ok, sid_wr, seq_wr, drop, pop, nonempty;

    assign nonempty = count_q != '0;
    assign free     = (PW+1)'(FIFO_DEPTH) - count_q;
    assign sid_ok   = sid_v_i && sid_cnt_i != '0;
    assign seq_ok   = seq_v_i && seq_cnt_i != '0;
    // The session-spanning report is older, so it claims the last free slot
    assign sid_wr   = sid_ok && free != '0;
    assign seq_wr   = seq_ok && (sid_ok ? free >= (PW+1)'(2) : free != '0);
    assign seq_wa   = sid_wr ? wp_q + PW'(1) : wp_q;
    assign drop     = (sid_ok && !sid_wr) || (seq_ok && !seq_wr);
    assign chunk    = rem_q < SEQ_NUM_W'(MAX_REQ_CNT) ? rem_q : SEQ_NUM_W'(MAX_REQ_CNT);
    assign rem_left = rem_q - chunk;

    assign req_v_o       = state_q == SEND;
    assign req_sid_o     = cur_sid_q;
    assign req_seq_num_o = cur_seq_q;
    assign req_cnt_o     = ML_W'(chunk);
    assign busy_o        = nonempty || state_q != IDLE;
    assign ovf_o         = ovf_q;

    always_ff @(posedge clk) begin
        if (!flush_i && sid_wr) begin
            sid_mem[wp_q]   <= sid_sid_i;
            start_mem[wp_q] <= sid_start_i;
            cnt_mem[wp_q]   <= sid_cnt_i;
        end
        if (!flush_i && seq_wr) begin
            sid_mem[seq_wa]   <= seq_sid_i;
            start_mem[seq_wa] <= seq_start_i;
            cnt_mem[seq_wa]   <= seq_cnt_i;
        end
    end

    // A SEND target with nothing left to send collapses to IDLE
    always_comb begin
        state_d   = state_q;
        cur_sid_d = cur_sid_q;
        cur_seq_d = cur_seq_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = nonempty;
                state_d = SEND;
            end
            SEND: if (req_ready_i) begin
                cur_seq_d = cur_seq_q + chunk;
                rem_d     = rem_left;
                gap_d     = GAP_W'(GAP_CYC);
                state_d   = GAP_CYC > 0 ? GAP : SEND;
                pop       = GAP_CYC == 0 && rem_left == '0 && nonempty;
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = SEND;
                    pop     = rem_q == '0 && nonempty;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            cur_sid_d = sid_mem[rp_q];
            cur_seq_d = start_mem[rp_q];
            rem_d     = cnt_mem[rp_q];
        end
        if (state_d == SEND && rem_d == '0) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rp_q      <= '0;
            wp_q      <= '0;
            count_q   <= '0;
            cur_sid_q <= '0;
            cur_seq_q <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rp_q      <= rp_q + PW'(pop);
            wp_q      <= wp_q + PW'(sid_wr) + PW'(seq_wr);
            count_q   <= count_q + (PW+1)'(sid_wr) + (PW+1)'(seq_wr) - (PW+1)'(pop);
            cur_sid_q <= cur_sid_d;
            cur_seq_q <= cur_seq_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_q | drop;
        end
    end
endmodule

// File: tb/tb_miss_req_sched.sv
// tb_miss_req_sched: directed and random reports; a monitor checks every presented
// request against a queue of expected chunks built from whole ranges.
module tb_miss_req_sched;
    localparam int MAXC = 64;
    localparam int GAPC = 2;
    localparam int DEPTH = 4;

    typedef struct {
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        bit          first;
        bit          last;
    } chunk_t;

    logic        clk, reset, flush_i, seq_v_i, sid_v_i, req_ready_i;
    logic        req_v_o, busy_o, ovf_o;
    logic [79:0] seq_sid_i, sid_sid_i, req_sid_o;
    logic [63:0] seq_start_i, seq_cnt_i, sid_start_i, sid_cnt_i, req_seq_num_o;
    logic [15:0] req_cnt_o;

    chunk_t      exp_q[$];
    chunk_t      me;
    int          n_checks = 0, n_fail = 0, issued = 0, done_ranges = 0, low = 0;
    bit          rand_rdy = 0, prev_v = 0, prev_hs = 0, prev_flush = 0, hs_seen = 0, cur_last = 0;
    logic [79:0] prev_sid;
    logic [63:0] prev_seq;
    logic [15:0] prev_cnt;

    miss_req_sched #(.MAX_REQ_CNT(MAXC), .FIFO_DEPTH(DEPTH), .GAP_CYC(GAPC)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .seq_v_i(seq_v_i), .seq_sid_i(seq_sid_i), .seq_start_i(seq_start_i), .seq_cnt_i(seq_cnt_i),
        .sid_v_i(sid_v_i), .sid_sid_i(sid_sid_i), .sid_start_i(sid_start_i), .sid_cnt_i(sid_cnt_i),
        .req_v_o(req_v_o), .req_ready_i(req_ready_i), .req_sid_o(req_sid_o),
        .req_seq_num_o(req_seq_num_o), .req_cnt_o(req_cnt_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Split a whole range into the requests a compliant scheduler must emit
    function automatic void push_range(input logic [79:0] s, input logic [63:0] st, input logic [63:0] n);
        chunk_t c;
        bit f = 1;
        while (n != 0) begin
            c.sid = s;
            c.seq = st;
            c.cnt = 16'(n < 64'(MAXC) ? n : 64'(MAXC));
            c.first = f;
            c.last = n <= 64'(MAXC);
            exp_q.push_back(c);
            st += 64'(c.cnt);
            n -= 64'(c.cnt);
            f = 0;
        end
        issued++;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy) req_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic rpt(input bit sv, input logic [79:0] ss, input logic [63:0] st, input logic [63:0] sc,
                       input bit qv, input logic [79:0] qs, input logic [63:0] qt, input logic [63:0] qc,
                       input bit keep_q);
        sid_v_i = sv; sid_sid_i = ss; sid_start_i = st; sid_cnt_i = sc;
        seq_v_i = qv; seq_sid_i = qs; seq_start_i = qt; seq_cnt_i = qc;
        if (sv && sc != 0) push_range(ss, st, sc);
        if (qv && qc != 0 && keep_q) push_range(qs, qt, qc);
        cyc();
        sid_v_i = 0;
        seq_v_i = 0;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while ((busy_o || exp_q.size() != 0) && i < 3000) begin
            cyc();
            i++;
        end
        chk({nm, "_drained"}, 128'(exp_q.size()), 128'(0));
        chk({nm, "_busy"}, 128'(busy_o), 128'(0));
    endtask

    task automatic wait_v(input string nm);
        int i = 0;
        while (!req_v_o && i < 50) begin
            cyc();
            i++;
        end
        chk({nm, "_req_v"}, 128'(req_v_o), 128'(1));
    endtask

    task automatic do_flush();
        flush_i = 1;
        cyc();
        flush_i = 0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 0; prev_hs = 0; low = 0; hs_seen = 0; cur_last = 0;
        end else begin
            if (req_v_o && prev_v && !prev_hs) begin
                chk("hold_sid", 128'(req_sid_o), 128'(prev_sid));
                chk("hold_seq", 128'(req_seq_num_o), 128'(prev_seq));
                chk("hold_cnt", 128'(req_cnt_o), 128'(prev_cnt));
            end else if (req_v_o) begin
                if (exp_q.size() == 0) chk("unexpected_req", 128'(1), 128'(0));
                else begin
                    me = exp_q.pop_front();
                    chk("req_sid", 128'(req_sid_o), 128'(me.sid));
                    chk("req_seq", 128'(req_seq_num_o), 128'(me.seq));
                    chk("req_cnt", 128'(req_cnt_o), 128'(me.cnt));
                    if (!me.first) chk("gap_len", 128'(low), 128'(GAPC));
                    else if (hs_seen) chk("gap_min", 128'(low >= GAPC), 128'(1));
                    cur_last = me.last;
                end
            end
            if (prev_v && !prev_hs && !req_v_o) chk("req_v_dropped_without_flush", 128'(prev_flush), 128'(1));
            if (req_v_o && req_ready_i) begin
                hs_seen = 1;
                low = 0;
                if (cur_last) done_ranges++;
            end else if (!req_v_o) low++;
            prev_v = req_v_o;
            prev_hs = req_v_o && req_ready_i;
            prev_sid = req_sid_o;
            prev_seq = req_seq_num_o;
            prev_cnt = req_cnt_o;
            prev_flush = flush_i;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        reset = 1; flush_i = 0; req_ready_i = 0;
        sid_v_i = 0; sid_sid_i = 0; sid_start_i = 0; sid_cnt_i = 0;
        seq_v_i = 0; seq_sid_i = 0; seq_start_i = 0; seq_cnt_i = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_req_v", 128'(req_v_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_ovf", 128'(ovf_o), 128'(0));
        chk("rst_sid", 128'(req_sid_o), 128'(0));
        chk("rst_seq", 128'(req_seq_num_o), 128'(0));
        chk("rst_cnt", 128'(req_cnt_o), 128'(0));

        // Range split with pacing
        req_ready_i = 1;
        rpt(0, 0, 0, 0, 1, 80'd5, 64'd100, 64'd150, 1);
        wait_idle("split");
        chk("split_ovf", 128'(ovf_o), 128'(0));

        // Same-cycle reports: sid first
        rpt(1, 80'd3, 64'd7, 64'd10, 1, 80'd4, 64'd1, 64'd5, 1);
        wait_idle("both");
        chk("both_ovf", 128'(ovf_o), 128'(0));

        // Fill the FIFO while stalled, then overflow by one
        req_ready_i = 0;
        for (int i = 0; i < 5; i++) rpt(0, 0, 0, 0, 1, 80'(10 + i), 64'(1000 + i), 64'd1, 1);
        chk("fill_no_ovf", 128'(ovf_o), 128'(0));
        rpt(0, 0, 0, 0, 1, 80'd99, 64'd9999, 64'd1, 0);
        chk("full_ovf", 128'(ovf_o), 128'(1));
        chk("full_busy", 128'(busy_o), 128'(1));
        req_ready_i = 1;
        wait_idle("fill");
        chk("ovf_sticky", 128'(ovf_o), 128'(1));
        do_flush();
        chk("flush_clr_ovf", 128'(ovf_o), 128'(0));

        // One free slot with both valid: seq report is dropped
        req_ready_i = 0;
        for (int i = 0; i < 4; i++) rpt(0, 0, 0, 0, 1, 80'(20 + i), 64'(2000 + i), 64'd1, 1);
        chk("slot3_no_ovf", 128'(ovf_o), 128'(0));
        rpt(1, 80'd30, 64'd3000, 64'd2, 1, 80'd31, 64'd3100, 64'd2, 0);
        chk("one_slot_ovf", 128'(ovf_o), 128'(1));
        req_ready_i = 1;
        wait_idle("one_slot");

        // Stall then flush mid-SEND
        req_ready_i = 0;
        rpt(0, 0, 0, 0, 1, 80'd20, 64'd50, 64'd3, 1);
        wait_v("stall");
        repeat (10) cyc();
        chk("stall_v", 128'(req_v_o), 128'(1));
        chk("stall_seq", 128'(req_seq_num_o), 128'(50));
        chk("stall_cnt", 128'(req_cnt_o), 128'(3));
        do_flush();
        chk("flush_v", 128'(req_v_o), 128'(0));
        chk("flush_busy", 128'(busy_o), 128'(0));
        chk("flush_ovf", 128'(ovf_o), 128'(0));

        // Sequence-number wrap
        req_ready_i = 1;
        rpt(0, 0, 0, 0, 1, 80'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd130, 1);
        wait_idle("wrap");

        // Async reset while in GAP with a queued range
        rpt(1, 80'd1, 64'd0, 64'd200, 1, 80'd2, 64'd0, 64'd5, 1);
        wait_v("gap_rst");
        cyc();
        #1 reset = 1;
        exp_q.delete();
        #1;
        chk("arst_v", 128'(req_v_o), 128'(0));
        chk("arst_busy", 128'(busy_o), 128'(0));
        chk("arst_sid", 128'(req_sid_o), 128'(0));
        chk("arst_seq", 128'(req_seq_num_o), 128'(0));
        chk("arst_cnt", 128'(req_cnt_o), 128'(0));
        cyc();
        cyc();
        reset = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen |= req_v_o;
            cyc();
        end
        chk("no_req_after_rst", 128'(seen), 128'(0));

        // Random traffic with random backpressure, kept within FIFO capacity
        issued = done_ranges;
        rand_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            bit sv, qv;
            logic [63:0] sc, qc, st, qt;
            logic [79:0] ss, qs;
            int k;
            sv = $urandom_range(0, 2) == 0;
            qv = $urandom_range(0, 2) == 0;
            sc = 64'($urandom_range(0, 150));
            qc = 64'($urandom_range(0, 150));
            st = $urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(0, 127)) : {$urandom(), $urandom()};
            qt = {$urandom(), $urandom()};
            ss = {16'($urandom()), $urandom(), $urandom()};
            qs = {16'($urandom()), $urandom(), $urandom()};
            k = int'(sv && sc != 0) + int'(qv && qc != 0);
            if (issued - done_ranges + k <= DEPTH) rpt(sv, ss, st, sc, qv, qs, qt, qc, 1);
            else cyc();
        end
        wait_idle("rand");
        chk("rand_ovf", 128'(ovf_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
